// File: rtl/ftoi_pipe.sv
// Float-to-integer converter: two-stage pipeline with a valid/ready handshake.
// Stage 1 aligns the mantissa to the integer grid (round bit + sticky).
// Stage 2 rounds, range-checks and registers int_out / IV / IE.

package FPU_pkg;
  localparam logic [4:0] FPU_OP_CVTFI = 5'd10;
  localparam logic [4:0] FPU_OP_CVTFU = 5'd11;

  localparam logic [2:0] FPU_RM_RNE = 3'd0;
  localparam logic [2:0] FPU_RM_RTZ = 3'd1;
  localparam logic [2:0] FPU_RM_RDN = 3'd2;
  localparam logic [2:0] FPU_RM_RUP = 3'd3;
  localparam logic [2:0] FPU_RM_RMM = 3'd4;
endpackage

module ftoi_pipe
  import FPU_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [4:0]       op,
  input  logic [2:0]       rm,
  input  logic [MAN_W-1:0] man_a,
  input  logic [EXP_W-1:0] exp_a,
  input  logic             sgn_a,
  input  logic             zero_a,
  input  logic             inf_a,
  input  logic             sNaN_a,
  input  logic             qNaN_a,
  output logic [INT_W-1:0] int_out,
  output logic             IV,
  output logic             IE
);

  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  // Mantissa sits above an (INT_W+1)-bit field; the MAN_W bits below the
  // field collect everything that ends up in the sticky bit.
  localparam int EXT_W  = MAN_W + INT_W + 1;
  localparam int SH_MAX = INT_W + 1;

  localparam logic [INT_W-1:0] MAX_S = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_S = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] ALL1  = {INT_W{1'b1}};
  localparam logic [INT_W:0]   LIM_S_POS = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   LIM_S_NEG = {2'b01, {(INT_W-1){1'b0}}};

  // handshake
  logic w_enable;
  logic w_op_ok;
  logic w_xfer;

  // stage-1 registers
  logic             r_s1_valid;
  logic [4:0]       r_s1_op;
  logic [2:0]       r_s1_rm;
  logic             r_s1_sgn;
  logic             r_s1_zero;
  logic             r_s1_inf;
  logic             r_s1_nan;
  logic             r_s1_ovf;
  logic [INT_W-1:0] r_s1_mag;
  logic             r_s1_rnd;
  logic             r_s1_stk;

  // stage-2 registers
  logic             r_s2_valid;
  logic [INT_W-1:0] r_s2_int;
  logic             r_s2_iv;
  logic             r_s2_ie;

  // alignment
  int               w_offset;
  int               w_shamt;
  logic             w_ovf;
  logic [EXT_W-1:0] w_ext;
  logic [EXT_W-1:0] w_shifted;
  logic [INT_W-1:0] w_mag;
  logic             w_rnd;
  logic             w_stk;

  // rounding / range
  logic             w_inc;
  logic [INT_W:0]   w_mag_r;
  logic [INT_W-1:0] w_mag_t;
  logic             w_unsigned;
  logic             w_in_range;
  logic [INT_W-1:0] w_res;
  logic             w_iv;
  logic             w_ie;

  assign w_enable  = !r_s2_valid || ready_in;
  assign w_op_ok   = (op == FPU_OP_CVTFI) || (op == FPU_OP_CVTFU);
  assign ready_out = w_enable && w_op_ok;
  assign w_xfer    = valid_in && ready_out;

  assign valid_out = r_s2_valid && !flush;
  assign int_out   = r_s2_int;
  assign IV        = r_s2_iv;
  assign IE        = r_s2_ie;

  // Align the mantissa so the field LSB is the 2^-1 (round) position.
  always_comb begin
    w_offset = INT_W - 1 + BIAS - int'(exp_a);
    w_ovf    = (w_offset < 0);
    if (w_ovf)
      w_shamt = 0;
    else if (w_offset > SH_MAX)
      w_shamt = SH_MAX;
    else
      w_shamt = w_offset;
    // Saturating at INT_W+1 pushes the whole mantissa below the field
    // without losing any set bit off the bottom, so sticky stays exact.
    w_ext     = {man_a, {(INT_W+1){1'b0}}};
    w_shifted = w_ext >> w_shamt;
    w_mag     = w_shifted[EXT_W-1 -: INT_W];
    w_rnd     = w_shifted[MAN_W];
    w_stk     = |w_shifted[MAN_W-1:0];
  end

  // Stage 1: capture operand class and aligned magnitude.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_rm    <= '0;
      r_s1_sgn   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_rnd   <= 1'b0;
      r_s1_stk   <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_enable) begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_op   <= op;
        r_s1_rm   <= rm;
        r_s1_sgn  <= sgn_a;
        r_s1_zero <= zero_a;
        r_s1_inf  <= inf_a;
        r_s1_nan  <= sNaN_a || qNaN_a;
        r_s1_ovf  <= w_ovf;
        r_s1_mag  <= w_mag;
        r_s1_rnd  <= w_rnd;
        r_s1_stk  <= w_stk;
      end
    end
  end

  // Round the magnitude, range-check the rounded value, pick the result.
  always_comb begin
    w_inc = 1'b0;
    case (r_s1_rm)
      FPU_RM_RNE: w_inc = r_s1_rnd && (r_s1_stk || r_s1_mag[0]);
      FPU_RM_RTZ: w_inc = 1'b0;
      FPU_RM_RDN: w_inc = r_s1_sgn && (r_s1_rnd || r_s1_stk);
      FPU_RM_RUP: w_inc = !r_s1_sgn && (r_s1_rnd || r_s1_stk);
      FPU_RM_RMM: w_inc = r_s1_rnd;
      default:    w_inc = 1'b0;
    endcase
    w_mag_r    = {1'b0, r_s1_mag} + {{INT_W{1'b0}}, w_inc};
    w_mag_t    = w_mag_r[INT_W-1:0];
    w_unsigned = (r_s1_op == FPU_OP_CVTFU);
    if (w_unsigned)
      w_in_range = r_s1_sgn ? (w_mag_r == '0) : !w_mag_r[INT_W];
    else
      w_in_range = r_s1_sgn ? (w_mag_r <= LIM_S_NEG) : (w_mag_r <= LIM_S_POS);

    w_res = '0;
    w_iv  = 1'b0;
    w_ie  = 1'b0;
    if (r_s1_nan) begin
      w_iv  = 1'b1;
      w_res = w_unsigned ? ALL1 : MAX_S;
    end else if (r_s1_zero) begin
      w_res = '0;
    end else if (r_s1_inf || r_s1_ovf || !w_in_range) begin
      w_iv = 1'b1;
      if (r_s1_sgn)
        w_res = w_unsigned ? '0 : MIN_S;
      else
        w_res = w_unsigned ? ALL1 : MAX_S;
    end else begin
      w_res = r_s1_sgn ? -w_mag_t : w_mag_t;
      w_ie  = r_s1_rnd || r_s1_stk;
    end
  end

  // Stage 2: result register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_int   <= '0;
      r_s2_iv    <= 1'b0;
      r_s2_ie    <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_enable) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_int <= w_res;
        r_s2_iv  <= w_iv;
        r_s2_ie  <= w_ie;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe (32-bit and 64-bit instances) with a
// result scoreboard per instance.

module tb_ftoi_pipe;
  import FPU_pkg::*;

  typedef struct {
    logic [63:0] val;
    logic        iv;
    logic        ie;
    string       tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t m32_e;
  exp_t m64_e;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic reset;

  // 32-bit instance
  logic        flush, valid_in, ready_out, valid_out, ready_in;
  logic [4:0]  op;
  logic [2:0]  rm;
  logic [23:0] man_a;
  logic [7:0]  exp_a;
  logic        sgn_a, zero_a, inf_a, sNaN_a, qNaN_a;
  logic [31:0] int_out;
  logic        IV, IE;

  // 64-bit instance
  logic        flush_64, valid_in_64, ready_out_64, valid_out_64, ready_in_64;
  logic [4:0]  op_64;
  logic [2:0]  rm_64;
  logic [52:0] man_a_64;
  logic [10:0] exp_a_64;
  logic        sgn_a_64, zero_a_64, inf_a_64, sNaN_a_64, qNaN_a_64;
  logic [63:0] int_out_64;
  logic        IV_64, IE_64;

  always #5 clk = ~clk;

  ftoi_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .op(op), .rm(rm),
    .man_a(man_a), .exp_a(exp_a), .sgn_a(sgn_a), .zero_a(zero_a),
    .inf_a(inf_a), .sNaN_a(sNaN_a), .qNaN_a(qNaN_a),
    .int_out(int_out), .IV(IV), .IE(IE)
  );

  ftoi_pipe #(.EXP_W(11), .MAN_W(53), .INT_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush_64),
    .valid_in(valid_in_64), .ready_out(ready_out_64),
    .valid_out(valid_out_64), .ready_in(ready_in_64),
    .op(op_64), .rm(rm_64),
    .man_a(man_a_64), .exp_a(exp_a_64), .sgn_a(sgn_a_64), .zero_a(zero_a_64),
    .inf_a(inf_a_64), .sNaN_a(sNaN_a_64), .qNaN_a(qNaN_a_64),
    .int_out(int_out_64), .IV(IV_64), .IE(IE_64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // kind: 0 normal, 1 zero, 2 inf, 3 sNaN, 4 qNaN
  task automatic send32(input logic [23:0] m, input logic [7:0] e, input logic s,
                        input int kind, input logic [4:0] o, input logic [2:0] r,
                        input logic [31:0] ev, input logic eiv, input logic eie,
                        input bit push, input string tag);
    exp_t x;
    bit   fired = 0;
    man_a = m; exp_a = e; sgn_a = s;
    zero_a = (kind == 1); inf_a = (kind == 2);
    sNaN_a = (kind == 3); qNaN_a = (kind == 4);
    op = o; rm = r; valid_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_out) begin
        fired = 1;
        break;
      end
    end
    if (!fired) chk({tag, "_send_timeout"}, ready_out, 1);
    else if (push) begin
      x.val = {32'd0, ev}; x.iv = eiv; x.ie = eie; x.tag = tag;
      q32.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  task automatic send64(input logic [52:0] m, input logic [10:0] e, input logic s,
                        input logic [4:0] o, input logic [2:0] r,
                        input logic [63:0] ev, input logic eiv, input logic eie,
                        input string tag);
    exp_t x;
    bit   fired = 0;
    man_a_64 = m; exp_a_64 = e; sgn_a_64 = s;
    zero_a_64 = 1'b0; inf_a_64 = 1'b0; sNaN_a_64 = 1'b0; qNaN_a_64 = 1'b0;
    op_64 = o; rm_64 = r; valid_in_64 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready_out_64) begin
        fired = 1;
        break;
      end
    end
    if (!fired) chk({tag, "_send_timeout"}, ready_out_64, 1);
    else begin
      x.val = ev; x.iv = eiv; x.ie = eie; x.tag = tag;
      q64.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200; k++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_q32_left"}, q32.size(), 0);
    chk({tag, "_q64_left"}, q64.size(), 0);
  endtask

  // Scoreboard pop on each output handshake of the 32-bit instance.
  always @(negedge clk) begin
    if (valid_out && ready_in) begin
      if (q32.size() == 0) chk("unexpected_out32", valid_out, 0);
      else begin
        m32_e = q32.pop_front();
        chk({m32_e.tag, "_val"}, int_out, m32_e.val);
        chk({m32_e.tag, "_iv"}, IV, m32_e.iv);
        chk({m32_e.tag, "_ie"}, IE, m32_e.ie);
      end
    end
  end

  // Scoreboard pop on each output handshake of the 64-bit instance.
  always @(negedge clk) begin
    if (valid_out_64 && ready_in_64) begin
      if (q64.size() == 0) chk("unexpected_out64", valid_out_64, 0);
      else begin
        m64_e = q64.pop_front();
        chk({m64_e.tag, "_val"}, int_out_64, m64_e.val);
        chk({m64_e.tag, "_iv"}, IV_64, m64_e.iv);
        chk({m64_e.tag, "_ie"}, IE_64, m64_e.ie);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [4:0] FI = FPU_OP_CVTFI;
  localparam logic [4:0] FU = FPU_OP_CVTFU;
  localparam logic [2:0] RNE = FPU_RM_RNE;
  localparam logic [2:0] RTZ = FPU_RM_RTZ;
  localparam logic [2:0] RDN = FPU_RM_RDN;
  localparam logic [2:0] RUP = FPU_RM_RUP;
  localparam logic [2:0] RMM = FPU_RM_RMM;

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    op = FI; rm = RNE; man_a = '0; exp_a = '0;
    sgn_a = 0; zero_a = 0; inf_a = 0; sNaN_a = 0; qNaN_a = 0;
    flush_64 = 1'b0; valid_in_64 = 1'b0; ready_in_64 = 1'b1;
    op_64 = FI; rm_64 = RNE; man_a_64 = '0; exp_a_64 = '0;
    sgn_a_64 = 0; zero_a_64 = 0; inf_a_64 = 0; sNaN_a_64 = 0; qNaN_a_64 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_int_out", int_out, 0);
    chk("rst_iv", IV, 0);
    chk("rst_ie", IE, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_out", ready_out, 1);
    @(posedge clk); #1;

    // unsupported op never handshakes
    op = 5'd0; valid_in = 1'b1;
    @(negedge clk);
    chk("bad_op_ready_out", ready_out, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;

    // back-to-back stream, downstream always ready
    send32(24'hA00000, 8'h80, 0, 0, FI, RNE, 32'h00000002, 0, 1, 1, "2p5_rne");
    send32(24'hA00000, 8'h80, 0, 0, FI, RMM, 32'h00000003, 0, 1, 1, "2p5_rmm");
    send32(24'hA00000, 8'h80, 1, 0, FI, RDN, 32'hFFFFFFFD, 0, 1, 1, "m2p5_rdn");
    send32(24'hA00000, 8'h80, 1, 0, FI, RUP, 32'hFFFFFFFE, 0, 1, 1, "m2p5_rup");
    send32(24'hA00000, 8'h80, 0, 0, FI, RTZ, 32'h00000002, 0, 1, 1, "2p5_rtz");
    send32(24'hA00000, 8'h80, 0, 0, FI, 3'd7, 32'h00000002, 0, 1, 1, "2p5_rm7");
    send32(24'h800000, 8'h9E, 1, 0, FI, RTZ, 32'h80000000, 0, 0, 1, "min_s");
    send32(24'h800000, 8'h9E, 0, 0, FI, RNE, 32'h7FFFFFFF, 1, 0, 1, "pow31_s");
    send32(24'hC00000, 8'hFF, 0, 4, FU, RNE, 32'hFFFFFFFF, 1, 0, 1, "qnan_u");
    send32(24'h99999A, 8'h7D, 1, 0, FU, RTZ, 32'h00000000, 0, 1, 1, "m0p3_u");
    send32(24'hB33333, 8'h7E, 1, 0, FU, RNE, 32'h00000000, 1, 0, 1, "m0p7_u");
    send32(24'h800000, 8'h7E, 1, 0, FU, RNE, 32'h00000000, 0, 1, 1, "m0p5_u");
    send32(24'h000000, 8'h00, 1, 1, FI, RNE, 32'h00000000, 0, 0, 1, "mzero");
    send32(24'h800000, 8'hFF, 1, 2, FI, RNE, 32'h80000000, 1, 0, 1, "minf_s");
    send32(24'h800000, 8'hFF, 0, 2, FU, RNE, 32'hFFFFFFFF, 1, 0, 1, "pinf_u");
    send32(24'h800000, 8'hFF, 1, 2, FU, RNE, 32'h00000000, 1, 0, 1, "minf_u");
    send32(24'hFFFFFF, 8'h9E, 0, 0, FU, RNE, 32'hFFFFFF00, 0, 0, 1, "max_u");
    send32(24'h800000, 8'h9F, 0, 0, FU, RNE, 32'hFFFFFFFF, 1, 0, 1, "pow32_u");
    send32(24'hC00000, 8'hFF, 0, 3, FI, RNE, 32'h7FFFFFFF, 1, 0, 1, "snan_s");
    send32(24'hE00000, 8'h80, 0, 0, FI, RNE, 32'h00000004, 0, 1, 1, "3p5_rne");
    send32(24'h800000, 8'h7F, 0, 0, FU, RNE, 32'h00000001, 0, 0, 1, "one_u");
    send32(24'h800000, 8'h7E, 1, 0, FI, RDN, 32'hFFFFFFFF, 0, 1, 1, "m0p5_rdn");
    send32(24'h800000, 8'h7E, 1, 0, FI, RUP, 32'h00000000, 0, 1, 1, "m0p5_rup");
    send32(24'hFFFFFF, 8'h9D, 0, 0, FI, RNE, 32'h7FFFFF80, 0, 0, 1, "near_max_s");
    valid_in = 1'b0;
    drain("stream");

    // back-pressure: downstream stalls 3 cycles while the pipe is full
    send32(24'hE00000, 8'h80, 0, 0, FI, RNE, 32'h00000004, 0, 1, 1, "bp_a");
    fork
      begin
        @(posedge clk); #1;
        ready_in = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_out", ready_out, 0);
          chk("stall_valid_out", valid_out, 1);
          chk("stall_hold_val", int_out, 32'h00000004);
          chk("stall_hold_ie", IE, 1);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join_none
    send32(24'hA00000, 8'h80, 0, 0, FI, RMM, 32'h00000003, 0, 1, 1, "bp_b");
    send32(24'hA00000, 8'h80, 1, 0, FI, RNE, 32'hFFFFFFFE, 0, 1, 1, "bp_c");
    send32(24'h800000, 8'h7F, 0, 0, FU, RNE, 32'h00000001, 0, 0, 1, "bp_d");
    valid_in = 1'b0;
    drain("backpressure");

    // flush with two in flight plus a simultaneous input
    ready_in = 1'b0;
    send32(24'hA00000, 8'h80, 0, 0, FI, RMM, 32'h0, 0, 0, 0, "fl_x");
    send32(24'hE00000, 8'h80, 0, 0, FI, RNE, 32'h0, 0, 0, 0, "fl_y");
    flush = 1'b1;
    man_a = 24'h800000; exp_a = 8'h7F; valid_in = 1'b1;
    @(negedge clk);
    chk("flush_mask_valid_out", valid_out, 0);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("post_flush_valid_out", valid_out, 0);
    @(posedge clk); #1;
    ready_in = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("flush_no_stale", valid_out, 0);
    @(posedge clk); #1;

    // reset with two in flight
    ready_in = 1'b0;
    send32(24'hA00000, 8'h80, 0, 0, FI, RMM, 32'h0, 0, 0, 0, "rs_x");
    send32(24'hE00000, 8'h80, 0, 0, FI, RNE, 32'h0, 0, 0, 0, "rs_y");
    valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_valid_out", valid_out, 0);
    chk("rst2_int_out", int_out, 0);
    chk("rst2_iv", IV, 0);
    chk("rst2_ie", IE, 0);
    @(posedge clk); #1;
    ready_in = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst2_no_stale", valid_out, 0);
    @(posedge clk); #1;

    // 64-bit instance
    send64(53'h18000000000000, 11'h3FF, 0, FI, RNE, 64'd2, 0, 1, "d_1p5_rne");
    send64(53'h10000000000000, 11'h43E, 0, FI, RNE, 64'h7FFFFFFFFFFFFFFF, 1, 0, "d_pow63_s");
    send64(53'h10000000000000, 11'h43E, 1, FI, RTZ, 64'h8000000000000000, 0, 0, "d_min_s");
    send64(53'h10000000000000, 11'h3FF, 1, FU, RNE, 64'd0, 1, 0, "d_m1_u");
    send64(53'h10000000000000, 11'h3FF, 0, FI, RNE, 64'd1, 0, 0, "d_one_s");
    valid_in_64 = 1'b0;
    drain("wide");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
